// File: rtl/button_conditioner.sv
// -----------------------------------------------------------------------------
// button_conditioner
//
// Input front-end for the pet control unit. Each raw board input is brought
// into the clock domain with a two-flop synchronizer and filtered by its own
// debouncer. Sleep/awake/feed/play become one-cycle press pulses; the tilt
// switch is passed on as a debounced level. The test button drives a
// long-press state machine that counts short presses while in test mode and
// reports the count on exit.
//
// Ports:
//   clk                         system clock, rising edge
//   rst                         synchronous reset, active low
//   rawSleep/rawAwake/rawFeed/rawPlay  asynchronous buttons, active high
//   rawGiro                     asynchronous tilt switch, active high
//   rawTest                     asynchronous test button, active high
//   botonSleep/Awake/Feed/Play  one-cycle press pulses (muted in test mode)
//   giro                        debounced tilt level
//   botonTest                   one-cycle pulse when test mode is left
//   pulseTest[3:0]              short-press count, held until next botonTest
//   testMode                    high while test presses are being counted
// -----------------------------------------------------------------------------
module button_conditioner #(
  parameter int DEBOUNCE   = 4,
  parameter int LONG_PRESS = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rawSleep,
  input  logic       rawAwake,
  input  logic       rawFeed,
  input  logic       rawPlay,
  input  logic       rawGiro,
  input  logic       rawTest,
  output logic       botonSleep,
  output logic       botonAwake,
  output logic       botonFeed,
  output logic       botonPlay,
  output logic       giro,
  output logic       botonTest,
  output logic [3:0] pulseTest,
  output logic       testMode
);

  localparam int NCH   = 6;
  localparam int CNT_W = $clog2(DEBOUNCE);
  localparam int HC_W  = $clog2(LONG_PRESS);

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE - 1);
  localparam logic [HC_W-1:0]  LP_LAST = HC_W'(LONG_PRESS - 1);

  localparam int CH_SLEEP = 0;
  localparam int CH_AWAKE = 1;
  localparam int CH_FEED  = 2;
  localparam int CH_PLAY  = 3;
  localparam int CH_GIRO  = 4;
  localparam int CH_TEST  = 5;

  typedef enum logic [2:0] {
    IDLE,
    N_PRESS,
    WAIT_IN,
    TEST,
    T_PRESS,
    WAIT_OUT
  } state_t;

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  logic [NCH-1:0]   raw_vec;
  logic [NCH-1:0]   sync_p0;
  logic [NCH-1:0]   sync_p1;
  logic [NCH-1:0]   deb_p2;
  logic [NCH-1:0]   deb_p3;
  logic [CNT_W-1:0] cnt_p2 [NCH];

  state_t           state;
  logic [HC_W-1:0]  hc;
  logic [3:0]       pc;
  logic             dt;

  assign raw_vec = {rawTest, rawGiro, rawPlay, rawFeed, rawAwake, rawSleep};
  assign dt      = deb_p2[CH_TEST];
  assign giro    = deb_p2[CH_GIRO];

  // Stage p0/p1: two-flop synchronizer. Stage p2: debounced value.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
      deb_p2  <= '0;
      for (int i = 0; i < NCH; i++) begin
        cnt_p2[i] <= '0;
      end
    end else begin
      sync_p0 <= raw_vec;
      sync_p1 <= sync_p0;
      for (int i = 0; i < NCH; i++) begin
        // The counter measures how long the input has disagreed with the
        // debounced value; any agreement restarts the measurement.
        if (sync_p1[i] == deb_p2[i]) begin
          cnt_p2[i] <= '0;
        end else if (cnt_p2[i] == DB_LAST) begin
          deb_p2[i] <= sync_p1[i];
          cnt_p2[i] <= '0;
        end else begin
          cnt_p2[i] <= cnt_p2[i] + CNT_W'(1);
        end
      end
    end
  end

  // Stage p3: rising-edge detection into registered press pulses.
  always_ff @(posedge clk) begin
    if (!rst) begin
      deb_p3     <= '0;
      botonSleep <= 1'b0;
      botonAwake <= 1'b0;
      botonFeed  <= 1'b0;
      botonPlay  <= 1'b0;
    end else begin
      deb_p3     <= deb_p2;
      botonSleep <= deb_p2[CH_SLEEP] & ~deb_p3[CH_SLEEP] & ~testMode;
      botonAwake <= deb_p2[CH_AWAKE] & ~deb_p3[CH_AWAKE] & ~testMode;
      botonFeed  <= deb_p2[CH_FEED]  & ~deb_p3[CH_FEED]  & ~testMode;
      botonPlay  <= deb_p2[CH_PLAY]  & ~deb_p3[CH_PLAY]  & ~testMode;
    end
  end

  // Stage p3: long-press state machine on the debounced test button.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      hc        <= '0;
      pc        <= 4'd0;
      pulseTest <= 4'd0;
      botonTest <= 1'b0;
      testMode  <= 1'b0;
    end else begin
      botonTest <= 1'b0;
      case (state)
        IDLE: begin
          if (dt) begin
            state <= N_PRESS;
            hc    <= '0;
          end
        end
        N_PRESS: begin
          // Released early: an ordinary short press, ignored outside test mode.
          if (!dt) begin
            state <= IDLE;
          end else if (hc == LP_LAST) begin
            state    <= WAIT_IN;
            pc       <= 4'd0;
            testMode <= 1'b1;
          end else begin
            hc <= hc + HC_W'(1);
          end
        end
        WAIT_IN: begin
          // The entering long press must be released before counting starts.
          if (!dt) begin
            state <= TEST;
          end
        end
        TEST: begin
          if (dt) begin
            state <= T_PRESS;
            hc    <= '0;
          end
        end
        T_PRESS: begin
          if (!dt) begin
            state <= TEST;
            pc    <= sat_inc(pc);
          end else if (hc == LP_LAST) begin
            // The exiting long press itself is not counted.
            state     <= WAIT_OUT;
            pulseTest <= pc;
            botonTest <= 1'b1;
            testMode  <= 1'b0;
          end else begin
            hc <= hc + HC_W'(1);
          end
        end
        WAIT_OUT: begin
          if (!dt) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_button_conditioner.sv
// -----------------------------------------------------------------------------
// tb_button_conditioner
//
// Self-checking bench for button_conditioner. Press pulses are tracked with
// a scoreboard of expected (cycle, channel) events filled when stimulus is
// driven and drained by a monitor; level outputs are checked inline by the
// scenario tasks. Inputs are driven and outputs sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_button_conditioner;

  localparam int DEBOUNCE   = 4;
  localparam int LONG_PRESS = 20;
  // Input changed at the falling edge of cycle n is first sampled at rising
  // edge n+1; the debounced value changes at edge n+2+DEBOUNCE and the press
  // pulse register at edge n+3+DEBOUNCE.
  localparam int LAT      = DEBOUNCE + 3;
  // The FSM enters a PRESS state one edge after dt rises (hc=0) and acts when
  // hc has reached LONG_PRESS-1, i.e. LONG_PRESS edges later.
  localparam int LONG_LAT = DEBOUNCE + 3 + LONG_PRESS;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rawSleep = 1'b0, rawAwake = 1'b0, rawFeed = 1'b0, rawPlay = 1'b0;
  logic       rawGiro = 1'b0, rawTest = 1'b0;
  logic       botonSleep, botonAwake, botonFeed, botonPlay;
  logic       giro, botonTest, testMode;
  logic [3:0] pulseTest;

  button_conditioner #(
    .DEBOUNCE  (DEBOUNCE),
    .LONG_PRESS(LONG_PRESS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rawSleep  (rawSleep),
    .rawAwake  (rawAwake),
    .rawFeed   (rawFeed),
    .rawPlay   (rawPlay),
    .rawGiro   (rawGiro),
    .rawTest   (rawTest),
    .botonSleep(botonSleep),
    .botonAwake(botonAwake),
    .botonFeed (botonFeed),
    .botonPlay (botonPlay),
    .giro      (giro),
    .botonTest (botonTest),
    .pulseTest (pulseTest),
    .testMode  (testMode)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    int ch;
  } exp_t;

  exp_t  sb[$];
  int    total = 0;
  int    bad   = 0;
  string pname [5] = '{"botonSleep", "botonAwake", "botonFeed", "botonPlay", "botonTest"};

  function automatic void expect_pulse(input int c, input int ch);
    exp_t e;
    e.cyc = c;
    e.ch  = ch;
    sb.push_back(e);
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic press_test(input int on, input int off);
    rawTest = 1'b1;
    tick(on);
    rawTest = 1'b0;
    tick(off);
  endtask

  // Pulse monitor: every observed pulse must match a scoreboard entry for
  // this cycle; any entry whose cycle has passed unmatched is a missed pulse.
  initial begin
    logic [4:0] p;
    int idx;
    forever begin
      @(negedge clk);
      p = {botonTest, botonPlay, botonFeed, botonAwake, botonSleep};
      for (int ch = 0; ch < 5; ch++) begin
        if (p[ch] === 1'b1) begin
          idx = -1;
          foreach (sb[i]) begin
            if (idx < 0 && sb[i].cyc == cyc && sb[i].ch == ch) idx = i;
          end
          total++;
          if (idx < 0) begin
            bad++;
            $display("FAIL pulse_%s: got pulse at cycle %0d, required none", pname[ch], cyc);
          end else begin
            sb.delete(idx);
          end
        end
      end
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].cyc <= cyc) begin
          total++;
          bad++;
          $display("FAIL pulse_%s: got no pulse, required pulse at cycle %0d",
                   pname[sb[i].ch], sb[i].cyc);
          sb.delete(i);
        end
      end
    end
  end

  task automatic test_reset();
    int n;
    logic [9:0] outs;
    rst = 1'b0;
    {rawSleep, rawAwake, rawFeed, rawPlay, rawGiro, rawTest} = 6'b111111;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      outs = {botonSleep, botonAwake, botonFeed, botonPlay, giro, botonTest, pulseTest, testMode};
      total++;
      if (outs !== 10'd0) begin
        bad++;
        $display("FAIL reset_outputs: got %b, required 0", outs);
      end
    end
    rst = 1'b1;
    n = cyc;
    for (int ch = 0; ch < 4; ch++) expect_pulse(n + LAT, ch);
    wait_cyc(n + LAT - 2);
    total++;
    if (giro !== 1'b0) begin
      bad++;
      $display("FAIL reset_giro_early: got %b, required 0", giro);
    end
    wait_cyc(n + LAT - 1);
    total++;
    if (giro !== 1'b1) begin
      bad++;
      $display("FAIL reset_giro_rise: got %b, required 1", giro);
    end
    wait_cyc(n + 12);
    {rawSleep, rawAwake, rawFeed, rawPlay, rawGiro, rawTest} = 6'b000000;
    tick(20);
    total++;
    if (testMode !== 1'b0 || giro !== 1'b0) begin
      bad++;
      $display("FAIL reset_release_levels: got testMode=%b giro=%b, required 0 0", testMode, giro);
    end
  endtask

  task automatic test_glitch();
    int n;
    rawFeed = 1'b1;
    tick(DEBOUNCE - 1);
    rawFeed = 1'b0;
    tick(15);
    n = cyc;
    rawFeed = 1'b1;
    expect_pulse(n + LAT, 2);
    tick(40);
    rawFeed = 1'b0;
    tick(15);
    total++;
    if (sb.size() !== 0) begin
      bad++;
      $display("FAIL glitch_pending: got %0d outstanding pulses, required 0", sb.size());
    end
  endtask

  task automatic test_enter();
    int n;
    n = cyc;
    rawTest = 1'b1;
    wait_cyc(n + LONG_LAT - 1);
    total++;
    if (testMode !== 1'b0) begin
      bad++;
      $display("FAIL enter_before: got testMode=%b, required 0", testMode);
    end
    wait_cyc(n + LONG_LAT);
    total++;
    if (testMode !== 1'b1) begin
      bad++;
      $display("FAIL enter_at: got testMode=%b, required 1", testMode);
    end
    wait_cyc(n + 30);
    rawTest = 1'b0;
    tick(12);
    rawPlay = 1'b1;
    tick(10);
    rawPlay = 1'b0;
    tick(10);
    n = cyc;
    rawGiro = 1'b1;
    wait_cyc(n + LAT - 2);
    total++;
    if (giro !== 1'b0) begin
      bad++;
      $display("FAIL enter_giro_early: got %b, required 0", giro);
    end
    wait_cyc(n + LAT - 1);
    total++;
    if (giro !== 1'b1) begin
      bad++;
      $display("FAIL enter_giro_rise: got %b, required 1", giro);
    end
    tick(5);
    rawGiro = 1'b0;
    tick(12);
    total++;
    if (giro !== 1'b0 || testMode !== 1'b1) begin
      bad++;
      $display("FAIL enter_levels: got giro=%b testMode=%b, required 0 1", giro, testMode);
    end
  endtask

  task automatic test_count_exit();
    int n;
    repeat (5) press_test(8, 8);
    n = cyc;
    rawTest = 1'b1;
    expect_pulse(n + LONG_LAT, 4);
    wait_cyc(n + LONG_LAT - 1);
    total++;
    if (testMode !== 1'b1 || pulseTest !== 4'd0) begin
      bad++;
      $display("FAIL exit_before: got testMode=%b pulseTest=%0d, required 1 0", testMode, pulseTest);
    end
    wait_cyc(n + LONG_LAT);
    total++;
    if (testMode !== 1'b0 || pulseTest !== 4'd5) begin
      bad++;
      $display("FAIL exit_at: got testMode=%b pulseTest=%0d, required 0 5", testMode, pulseTest);
    end
    wait_cyc(n + 30);
    rawTest = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick(1);
      total++;
      if (pulseTest !== 4'd5) begin
        bad++;
        $display("FAIL exit_hold: got pulseTest=%0d at cycle %0d, required 5", pulseTest, cyc);
      end
    end
  endtask

  task automatic test_saturation();
    int n;
    press_test(30, 12);
    total++;
    if (testMode !== 1'b1) begin
      bad++;
      $display("FAIL sat_enter: got testMode=%b, required 1", testMode);
    end
    repeat (20) press_test(8, 8);
    n = cyc;
    rawTest = 1'b1;
    expect_pulse(n + LONG_LAT, 4);
    wait_cyc(n + LONG_LAT - 1);
    total++;
    if (pulseTest !== 4'd5) begin
      bad++;
      $display("FAIL sat_before: got pulseTest=%0d, required 5", pulseTest);
    end
    wait_cyc(n + LONG_LAT);
    total++;
    if (pulseTest !== 4'd15 || testMode !== 1'b0) begin
      bad++;
      $display("FAIL sat_at: got pulseTest=%0d testMode=%b, required 15 0", pulseTest, testMode);
    end
    wait_cyc(n + 30);
    rawTest = 1'b0;
    tick(15);
  endtask

  task automatic test_abort();
    press_test(30, 12);
    repeat (3) press_test(8, 8);
    total++;
    if (testMode !== 1'b1 || pulseTest !== 4'd15) begin
      bad++;
      $display("FAIL abort_pre: got testMode=%b pulseTest=%0d, required 1 15", testMode, pulseTest);
    end
    rst = 1'b0;
    tick(1);
    rst = 1'b1;
    total++;
    if (testMode !== 1'b0 || pulseTest !== 4'd0) begin
      bad++;
      $display("FAIL abort_reset: got testMode=%b pulseTest=%0d, required 0 0", testMode, pulseTest);
    end
    tick(30);
    press_test(8, 8);
    tick(20);
    total++;
    if (testMode !== 1'b0 || pulseTest !== 4'd0) begin
      bad++;
      $display("FAIL abort_short: got testMode=%b pulseTest=%0d, required 0 0", testMode, pulseTest);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got no completion by %0t, required completion", $time);
    $fatal(1, "bench did not complete");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_glitch();
    test_enter();
    test_count_exit();
    test_saturation();
    test_abort();
    tick(20);
    total++;
    if (sb.size() !== 0) begin
      bad++;
      $display("FAIL final_pending: got %0d outstanding pulses, required 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
